metropolis_accept_unit: RTL and testbench
=========================================

# metropolis_accept_unit

Parametrised Metropolis acceptance unit for the probabilistic search stage. It decides whether the proposed assignment from the sample block replaces the current one, accepting with probability 2^(u−v) when u<v and always otherwise. It is the exact, pipelined, back-pressured successor of the single-width acceptance logic, and adds temperature scaling, a tag pass-through and acceptance statistics. It sits between the constraint-evaluation results (u, v) and the assignment-select multiplexer.

## Interface
- SCORE_W, 8: width of the unsigned satisfied-constraint counts u, v.
- RAND_W, 8: LFSR and random-draw width, range 4..32.
- TAG_W, 4: width of the opaque tag passed through with each transaction.
- CNT_W, 16: width of the statistics counters.
- SEED_DEFAULT, 1: LFSR value after reset; nonzero.
- in_clock  in  1  system clock, rising edge.
- in_reset_n  in  1  asynchronous active-low reset.
- in_seed_load  in  1  load in_seed into the LFSR on this edge.
- in_seed  in  RAND_W  seed; value 0 is replaced by 1.
- in_valid  in  1  transaction offered.
- in_ready  out  1  unit can accept a transaction this cycle.
- in_u  in  SCORE_W  satisfied count of the proposed assignment.
- in_v  in  SCORE_W  satisfied count of the current assignment.
- in_temp_shift  in  3  temperature: delta is arithmetically shifted right by this amount.
- in_tag  in  TAG_W  opaque tag, for example a variable index.
- out_valid  out  1  result available.
- out_ready  in  1  downstream takes the result.
- out_accept  out  1  1 = take the proposed assignment.
- out_tag  out  TAG_W  tag of this result.
- in_clear_stats  in  1  synchronous clear of both counters.
- out_total_count  out  CNT_W  completed transactions, saturating.
- out_accept_count  out  CNT_W  accepted transactions, saturating.

## Operation
- A transaction transfers when valid and ready are both high.
- Stage 1 (S1) registers the following:
  - d = u − v, signed, SCORE_W+1 bits.
  - d_eff = d >>> in_temp_shift. The shift is arithmetic and rounds toward −∞, so −1 >>> n = −1.
  - k = −d_eff when d_eff < 0, else 0. k is clamped to RAND_W.
  - the tag.
- Transfer S1→S2 uses r, the current LFSR state, and computes:
  - accept = 1 if k = 0.
  - accept = 1 if the top k bits of r are zero (r < 2^(RAND_W−k)), for 0 < k < RAND_W.
  - accept = 0 if k = RAND_W.
  - The result is registered into S2.
- LFSR: Fibonacci, maximal-length taps per RAND_W from the package.
  - Advances exactly once per S1→S2 transfer. The draw sequence therefore depends only on the seed and the transaction count, not on stalls.
  - in_seed_load overrides the advance in the same cycle.
- Statistics update on each output handshake (out_valid & out_ready):
  - total increments.
  - accept increments when out_accept = 1.
  - Both saturate at 2^CNT_W−1.
  - in_clear_stats wins over a simultaneous increment; the counters read 0 on the next cycle.

## Timing
- Reset values: in_ready=1, out_valid=0, out_accept=0, out_tag=0, both counters 0, LFSR=SEED_DEFAULT, S1 and S2 empty.
- Latency is 2 cycles from input handshake to out_valid.
- Throughput is 1 transaction per cycle while out_ready=1.
- Back-pressure:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 loads when S1 is empty or S1 is moving into S2.
  - in_ready = S1 empty OR S2 can load. This is combinational from out_ready; the full pipeline keeps no bubbles.
- Stalled out_valid=1 holds out_accept and out_tag stable until the handshake.
- A seed load while S1 holds a transaction means the pending draw uses the new seed if the transfer happens in a later cycle. If the transfer happens in the same cycle, it uses the old state.
- An asynchronous reset mid-operation drops all in-flight transactions. No output is produced for them.

## Structure
- Package mcmc_pkg holds:
  - the LFSR tap-mask function indexed by width (4..32);
  - the clamp helper;
  - shared SCORE_W/RAND_W defaults for the other probabilistic-search blocks.
- Sub-module lfsr_generator holds the parametrised LFSR with enable, seed load and zero-seed guard, and is reusable by the sample block.
- The top level holds the pipeline registers, compare logic and counters.

## Test plan
- Reset, then in_u=7, in_v=3, temp 0 → out_valid 2 cycles after the handshake with out_accept=1 and total=accept=1.
- RAND_W=8, seed load 0x3F, u=3, v=5 (k=2): r=0x3F → accept=1. The next draws follow the reference LFSR model, and the bench checks accept == (r[7:6]==0) for 1000 random transactions.
- u=0, v=200, temp 0 → k clamped to 8, accept=0 for all draws. The same case with temp 7 gives d_eff=−2 and accept matching the top-2-bits rule.
- Random out_ready stalls (50%) on 500 back-to-back transactions → the out_tag sequence is in order with no loss or duplication. The accept sequence is identical to the stall-free run with the same seed.
- CNT_W=4, 20 accepted transactions → counters saturate at 15. Asserting in_clear_stats in the same cycle as a handshake → counters read 0 next cycle.
- Assert in_reset_n low while S1 and S2 are full → all outputs return to their reset values immediately. After release, the first draw equals SEED_DEFAULT.

Source files
------------

// File: rtl/mcmc_pkg.sv
`default_nettype none
// ============================================================================
// Module     : mcmc_pkg
// Description: Shared definitions for the probabilistic-search blocks.
//              Provides the maximal-length LFSR tap table (widths 4..32),
//              a clamp helper and the default score / random-draw widths.
// Revision   : 1.0 - initial release
// ============================================================================
package mcmc_pkg;

  localparam int SCORE_W_DEFAULT = 8;
  localparam int RAND_W_DEFAULT  = 8;

  // Fibonacci feedback mask: bit (t-1) is set for every polynomial tap t.
  // These are primitive polynomials, so the XOR feedback walks all
  // 2^width-1 nonzero states.
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] mask;
    case (width)
      4:       mask = 32'h0000_000C;
      5:       mask = 32'h0000_0014;
      6:       mask = 32'h0000_0030;
      7:       mask = 32'h0000_0060;
      8:       mask = 32'h0000_00B8;
      9:       mask = 32'h0000_0110;
      10:      mask = 32'h0000_0240;
      11:      mask = 32'h0000_0500;
      12:      mask = 32'h0000_0829;
      13:      mask = 32'h0000_100D;
      14:      mask = 32'h0000_2015;
      15:      mask = 32'h0000_6000;
      16:      mask = 32'h0000_D008;
      17:      mask = 32'h0001_2000;
      18:      mask = 32'h0002_0400;
      19:      mask = 32'h0004_0023;
      20:      mask = 32'h0009_0000;
      21:      mask = 32'h0014_0000;
      22:      mask = 32'h0030_0000;
      23:      mask = 32'h0042_0000;
      24:      mask = 32'h00E1_0000;
      25:      mask = 32'h0120_0000;
      26:      mask = 32'h0200_0023;
      27:      mask = 32'h0400_0013;
      28:      mask = 32'h0900_0000;
      29:      mask = 32'h1400_0000;
      30:      mask = 32'h2000_0029;
      31:      mask = 32'h4800_0000;
      32:      mask = 32'h8020_0003;
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

  function automatic int unsigned clamp_u(input int unsigned value,
                                          input int unsigned limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_generator.sv
`default_nettype none
// ============================================================================
// Module     : lfsr_generator
// Description: Parametrised Fibonacci LFSR with advance enable, seed load
//              (takes priority over the advance) and a zero-seed guard.
// Ports      : in_clock     - rising-edge clock
//              in_reset_n   - asynchronous active-low reset
//              in_enable    - advance one step on this edge
//              in_seed_load - load in_seed on this edge
//              in_seed      - seed value (0 is replaced by 1)
//              out_state    - current LFSR state
// Revision   : 1.0 - initial release
// ============================================================================
module lfsr_generator
  import mcmc_pkg::*;
#(
  parameter int          WIDTH        = 8,
  parameter int unsigned SEED_DEFAULT = 1
) (
  input  logic             in_clock,
  input  logic             in_reset_n,
  input  logic             in_enable,
  input  logic             in_seed_load,
  input  logic [WIDTH-1:0] in_seed,
  output logic [WIDTH-1:0] out_state
);

  localparam logic [WIDTH-1:0] c_taps        = WIDTH'(lfsr_taps(WIDTH));
  // An all-zero state would lock the register, so a zero default maps to 1.
  localparam logic [WIDTH-1:0] c_reset_state =
    (WIDTH'(SEED_DEFAULT) == '0) ? WIDTH'(1) : WIDTH'(SEED_DEFAULT);

  logic [WIDTH-1:0] r_state;
  logic             w_feedback;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_seed;

  assign w_feedback = ^(r_state & c_taps);
  assign w_next     = {r_state[WIDTH-2:0], w_feedback};
  assign w_seed     = (in_seed == '0) ? WIDTH'(1) : in_seed;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_state <= c_reset_state;
    end else if (in_seed_load) begin
      r_state <= w_seed;
    end else if (in_enable) begin
      r_state <= w_next;
    end
  end

  assign out_state = r_state;

endmodule
`default_nettype wire

// File: rtl/metropolis_accept_unit.sv
`default_nettype none
// ============================================================================
// Module     : metropolis_accept_unit
// Description: Two-stage back-pressured Metropolis acceptance unit. Accepts
//              the proposed assignment with probability 2^(d_eff) when the
//              temperature-scaled score delta d_eff is negative, always
//              otherwise. Tags pass through; saturating statistics counters.
// Ports      : in_clock / in_reset_n      - clock, async active-low reset
//              in_seed_load / in_seed     - LFSR reseed
//              in_valid / in_ready        - input handshake
//              in_u, in_v, in_temp_shift  - scores and temperature
//              in_tag                     - opaque pass-through tag
//              out_valid / out_ready      - output handshake
//              out_accept / out_tag       - decision and its tag
//              in_clear_stats             - synchronous counter clear
//              out_total_count            - completed transactions
//              out_accept_count           - accepted transactions
// Revision   : 1.0 - initial release
// ============================================================================
module metropolis_accept_unit
  import mcmc_pkg::*;
#(
  parameter int          SCORE_W      = SCORE_W_DEFAULT,
  parameter int          RAND_W       = RAND_W_DEFAULT,
  parameter int          TAG_W        = 4,
  parameter int          CNT_W        = 16,
  parameter int unsigned SEED_DEFAULT = 1
) (
  input  logic               in_clock,
  input  logic               in_reset_n,
  input  logic               in_seed_load,
  input  logic [RAND_W-1:0]  in_seed,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCORE_W-1:0] in_u,
  input  logic [SCORE_W-1:0] in_v,
  input  logic [2:0]         in_temp_shift,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_accept,
  output logic [TAG_W-1:0]   out_tag,
  input  logic               in_clear_stats,
  output logic [CNT_W-1:0]   out_total_count,
  output logic [CNT_W-1:0]   out_accept_count
);

  localparam int               c_d_w     = SCORE_W + 1;
  localparam int               c_k_w     = $clog2(RAND_W + 1);
  localparam logic [c_k_w-1:0] c_k_max   = c_k_w'(RAND_W);
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  // Stage 1: clamped rejection exponent k and tag
  logic               r_s1_valid;
  logic [c_k_w-1:0]   r_s1_k;
  logic [TAG_W-1:0]   r_s1_tag;
  // Stage 2: decision presented downstream
  logic               r_s2_valid;
  logic               r_s2_accept;
  logic [TAG_W-1:0]   r_s2_tag;
  logic [CNT_W-1:0]   r_total;
  logic [CNT_W-1:0]   r_accepted;

  logic signed [c_d_w-1:0] w_d;
  logic signed [c_d_w-1:0] w_d_eff;
  logic [c_d_w-1:0]        w_mag;
  logic [c_k_w-1:0]        w_k;
  logic [RAND_W-1:0]       w_draw;
  logic [c_k_w-1:0]        w_shamt;
  logic                    w_top_zero;
  logic                    w_accept;
  logic                    w_s2_load;
  logic                    w_s1_move;
  logic                    w_in_fire;
  logic                    w_out_fire;

  // Zero-extended scores so the difference never overflows; the arithmetic
  // shift floors toward -inf, so a small negative delta never reaches 0.
  assign w_d     = signed'({1'b0, in_u}) - signed'({1'b0, in_v});
  assign w_d_eff = w_d >>> in_temp_shift;
  assign w_mag   = w_d_eff[c_d_w-1] ? unsigned'(-w_d_eff) : '0;
  assign w_k     = c_k_w'(clamp_u(32'(w_mag), 32'(RAND_W)));

  // Accept when the top k bits of the draw are zero, i.e. r < 2^(RAND_W-k).
  // k = RAND_W always rejects since the LFSR state is never zero.
  assign w_shamt    = c_k_max - r_s1_k;
  assign w_top_zero = ((w_draw >> w_shamt) == '0);
  assign w_accept   = (r_s1_k == '0) || ((r_s1_k < c_k_max) && w_top_zero);

  assign w_s2_load  = !r_s2_valid || out_ready;
  assign w_s1_move  = r_s1_valid && w_s2_load;
  assign in_ready   = !r_s1_valid || w_s2_load;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_s2_valid && out_ready;

  // One draw per S1->S2 transfer keeps the draw sequence stall-independent.
  lfsr_generator #(
    .WIDTH        (RAND_W),
    .SEED_DEFAULT (SEED_DEFAULT)
  ) u_lfsr (
    .in_clock     (in_clock),
    .in_reset_n   (in_reset_n),
    .in_enable    (w_s1_move),
    .in_seed_load (in_seed_load),
    .in_seed      (in_seed),
    .out_state    (w_draw)
  );

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_k     <= '0;
      r_s1_tag   <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_k     <= w_k;
      r_s1_tag   <= in_tag;
    end else if (w_s1_move) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_s2_valid  <= 1'b0;
      r_s2_accept <= 1'b0;
      r_s2_tag    <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_accept <= w_accept;
        r_s2_tag    <= r_s1_tag;
      end
    end
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      r_total    <= '0;
      r_accepted <= '0;
    end else if (in_clear_stats) begin
      r_total    <= '0;
      r_accepted <= '0;
    end else if (w_out_fire) begin
      if (r_total != c_cnt_max) begin
        r_total <= r_total + 1'b1;
      end
      if (r_s2_accept && (r_accepted != c_cnt_max)) begin
        r_accepted <= r_accepted + 1'b1;
      end
    end
  end

  assign out_valid        = r_s2_valid;
  assign out_accept       = r_s2_accept;
  assign out_tag          = r_s2_tag;
  assign out_total_count  = r_total;
  assign out_accept_count = r_accepted;

endmodule
`default_nettype wire

// File: tb/tb_metropolis_accept_unit.sv
`default_nettype none
// ============================================================================
// Module     : tb_metropolis_accept_unit
// Description: Scoreboard bench for metropolis_accept_unit (RAND_W=8,
//              CNT_W=4). Expected decisions come from a reference model of
//              the acceptance rule driven by a model of the draw sequence.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_metropolis_accept_unit;

  localparam int TAG_W = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             in_clock = 1'b0;
  logic             in_reset_n;
  logic             in_seed_load;
  logic [7:0]       in_seed;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_u;
  logic [7:0]       in_v;
  logic [2:0]       in_temp_shift;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             out_accept;
  logic [TAG_W-1:0] out_tag;
  logic             in_clear_stats;
  logic [CNT_W-1:0] out_total_count;
  logic [CNT_W-1:0] out_accept_count;

  metropolis_accept_unit #(
    .SCORE_W      (8),
    .RAND_W       (8),
    .TAG_W        (TAG_W),
    .CNT_W        (CNT_W),
    .SEED_DEFAULT (1)
  ) dut (
    .in_clock         (in_clock),
    .in_reset_n       (in_reset_n),
    .in_seed_load     (in_seed_load),
    .in_seed          (in_seed),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_u             (in_u),
    .in_v             (in_v),
    .in_temp_shift    (in_temp_shift),
    .in_tag           (in_tag),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_accept       (out_accept),
    .out_tag          (out_tag),
    .in_clear_stats   (in_clear_stats),
    .out_total_count  (out_total_count),
    .out_accept_count (out_accept_count)
  );

  always #5 in_clock = ~in_clock;

  typedef struct packed {
    logic             acc;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  logic act_acc[$];
  logic run1[$];

  int total_cnt   = 0;
  int bad_cnt     = 0;
  int model_r     = 1;
  int model_total = 0;
  int model_acc   = 0;
  bit stall_en    = 1'b0;

  int su[500];
  int sv[500];
  int ss[500];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req) begin
      bad_cnt++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Rejection exponent straight from the rule: floor(d / 2^s), negated when
  // negative, capped at the draw width.
  function automatic int model_k(input int u, input int v, input int s);
    int d, p, de, k;
    d = u - v;
    p = 1 << s;
    if (d >= 0) de = d / p;
    else        de = -((-d + p - 1) / p);
    if (de >= 0) return 0;
    k = -de;
    return (k > 8) ? 8 : k;
  endfunction

  // Draw sequence of x^8 + x^6 + x^5 + x^4 + 1, newest bit entering at the LSB.
  function automatic int lfsr_next(input int r);
    int fb;
    fb = ((r >> 7) ^ (r >> 5) ^ (r >> 4) ^ (r >> 3)) & 1;
    return ((r << 1) | fb) & 255;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the input handshake.
  task automatic send(input int u, input int v, input int s, input int tg);
    int   n;
    int   k;
    exp_t e;
    in_valid      = 1'b1;
    in_u          = 8'(u);
    in_v          = 8'(v);
    in_temp_shift = 3'(s);
    in_tag        = TAG_W'(tg);
    n = 0;
    @(negedge in_clock);
    while (!in_ready) begin
      n++;
      if (n > 300) begin
        chk("send_timeout", 32'(n), 0);
        in_valid = 1'b0;
        return;
      end
      @(negedge in_clock);
    end
    k     = model_k(u, v, s);
    e.acc = (model_r < (1 << (8 - k)));
    e.tag = TAG_W'(tg);
    exp_q.push_back(e);
    model_r = lfsr_next(model_r);
    @(posedge in_clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load_seed(input int s);
    in_seed_load = 1'b1;
    in_seed      = 8'(s);
    @(posedge in_clock);
    #1;
    in_seed_load = 1'b0;
    model_r      = ((s & 255) == 0) ? 1 : (s & 255);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge in_clock);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 0);
    repeat (2) @(posedge in_clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_in_ready"},   32'(in_ready), 1);
    chk({nm, "_out_valid"},  32'(out_valid), 0);
    chk({nm, "_out_accept"}, 32'(out_accept), 0);
    chk({nm, "_out_tag"},    32'(out_tag), 0);
    chk({nm, "_total"},      32'(out_total_count), 0);
    chk({nm, "_accepted"},   32'(out_accept_count), 0);
  endtask

  task automatic run_table();
    for (int i = 0; i < 500; i++) send(su[i], sv[i], ss[i], i % 16);
  endtask

  // Random out_ready while stall mode is on.
  initial begin
    forever begin
      @(posedge in_clock);
      #1;
      if (stall_en) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares counters every cycle and pops the scoreboard on
  // each output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge in_clock);
      if (in_reset_n) begin
        chk("total_count", 32'(out_total_count), 32'(model_total));
        chk("accept_count", 32'(out_accept_count), 32'(model_acc));
        if (out_valid && !out_ready && exp_q.size() != 0) begin
          chk("stall_accept", 32'(out_accept), 32'(exp_q[0].acc));
          chk("stall_tag", 32'(out_tag), 32'(exp_q[0].tag));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'(out_tag), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("accept", 32'(out_accept), 32'(e.acc));
            chk("tag", 32'(out_tag), 32'(e.tag));
            act_acc.push_back(out_accept);
            if (!in_clear_stats) begin
              if (model_total < CMAX) model_total++;
              if (e.acc && model_acc < CMAX) model_acc++;
            end
          end
        end
        if (in_clear_stats) begin
          model_total = 0;
          model_acc   = 0;
        end
      end
    end
  end

  initial begin
    int u;
    int v;
    int s;
    int diffs;
    in_reset_n     = 1'b0;
    in_seed_load   = 1'b0;
    in_seed        = '0;
    in_valid       = 1'b0;
    in_u           = '0;
    in_v           = '0;
    in_temp_shift  = '0;
    in_tag         = '0;
    out_ready      = 1'b1;
    in_clear_stats = 1'b0;
    repeat (3) @(posedge in_clock);
    #1;
    check_reset_outputs("reset");
    in_reset_n = 1'b1;

    // Latency: S1 after the handshake edge, out_valid one edge later.
    send(7, 3, 0, 5);
    chk("lat_s1_not_valid", 32'(out_valid), 0);
    @(posedge in_clock); #1;
    chk("lat_out_valid", 32'(out_valid), 1);
    chk("lat_accept", 32'(out_accept), 1);
    chk("lat_tag", 32'(out_tag), 5);
    @(posedge in_clock); #1;
    chk("lat_total", 32'(out_total_count), 1);
    chk("lat_accepted", 32'(out_accept_count), 1);
    drain();

    // Seed 0x3F with k=2: top two bits zero, so accept.
    load_seed(8'h3F);
    send(3, 5, 0, 1);
    drain();
    if (act_acc.size() != 0) chk("seed3f_accept", 32'(act_acc[$]), 1);

    for (int i = 0; i < 1000; i++) begin
      u = $urandom_range(0, 255);
      v = u + $urandom_range(0, 24) - 4;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 0;
      send(u, v, s, i % 16);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge in_clock); #1;
      end
    end
    drain();

    // Clamp to RAND_W (always reject), then temp 7 giving d_eff = -2.
    for (int i = 0; i < 16; i++) send(0, 200, 0, i);
    for (int i = 0; i < 32; i++) send(0, 200, 7, i % 16);
    drain();

    // Stall-free vs 50% stalled run with the same seed and stimulus.
    for (int i = 0; i < 500; i++) begin
      su[i] = $urandom_range(0, 255);
      sv[i] = su[i] + $urandom_range(0, 6);
      if (sv[i] > 255) sv[i] = 255;
      ss[i] = $urandom_range(0, 1);
    end
    load_seed(8'hA5);
    act_acc.delete();
    run_table();
    drain();
    run1 = act_acc;
    load_seed(8'hA5);
    act_acc.delete();
    stall_en = 1'b1;
    run_table();
    drain();
    stall_en  = 1'b0;
    out_ready = 1'b1;
    @(posedge in_clock); #1;
    chk("stall_run_len", 32'(act_acc.size()), 32'(run1.size()));
    diffs = 0;
    for (int i = 0; i < 500; i++) begin
      if (i < act_acc.size() && i < run1.size() && act_acc[i] !== run1[i]) diffs++;
    end
    chk("stall_seq_diffs", 32'(diffs), 0);

    // Saturation at 15, then clear coinciding with a handshake.
    in_clear_stats = 1'b1;
    @(posedge in_clock); #1;
    in_clear_stats = 1'b0;
    for (int i = 0; i < 20; i++) send(9, 9, 0, i % 16);
    drain();
    chk("sat_total", 32'(out_total_count), 15);
    chk("sat_accepted", 32'(out_accept_count), 15);
    send(1, 1, 0, 3);
    @(posedge in_clock); #1;
    chk("clr_out_valid", 32'(out_valid), 1);
    in_clear_stats = 1'b1;
    @(posedge in_clock); #1;
    in_clear_stats = 1'b0;
    chk("clr_total", 32'(out_total_count), 0);
    chk("clr_accepted", 32'(out_accept_count), 0);
    drain();

    // Reset with S1 and S2 both occupied.
    out_ready = 1'b0;
    send(4, 4, 0, 1);
    send(4, 4, 0, 2);
    chk("full_out_valid", 32'(out_valid), 1);
    chk("full_in_ready", 32'(in_ready), 0);
    #1;
    in_reset_n = 1'b0;
    exp_q.delete();
    model_r     = 1;
    model_total = 0;
    model_acc   = 0;
    #1;
    out_ready = 1'b1;
    check_reset_outputs("midreset");
    @(posedge in_clock); #1;
    in_reset_n = 1'b1;
    act_acc.delete();
    // k=7 accepts only r<2; the first draw after reset is 1.
    send(0, 7, 0, 6);
    drain();
    chk("post_reset_outputs", 32'(act_acc.size()), 1);
    if (act_acc.size() != 0) chk("post_reset_first_draw", 32'(act_acc[0]), 1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire
